mem_arbiter: RTL

Shares the single-port 4096×4 system RAM between the CPU register datapath and the LCD/display fetch engine. The CPU keeps absolute priority except when a display burst has been starved for `STARVE_LIMIT` consecutive cycles. In that case the arbiter stalls the CPU microcode sequencer for one cycle and services the display. Display requests are page-local bursts of 1–16 nibble reads with per-nibble valid strobes.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port 4096x4 RAM between the CPU datapath and the
//   display fetch engine. The CPU has priority. A display burst that has lost
//   arbitration STARVE_LIMIT cycles in a row gets the RAM for one cycle, and
//   the CPU is stalled for that cycle.
//
// Ports
//   clk, reset                 clock and asynchronous active-high reset
//   cpu_mem_en/_write_en       CPU access request and direction
//   cpu_addr/_write_data       CPU address and write nibble
//   cpu_read_data              RAM read data, valid the cycle after a CPU read
//   cpu_stall                  CPU access dropped, so the CPU repeats it next cycle
//   disp_req/_addr/_len        burst start pulse, start address and length-1
//   disp_busy                  burst in progress
//   disp_data/_data_valid      returned nibble and its strobe
//   disp_done                  high together with the final strobe of a burst
//   ram_addr/_write_en/_write_data/_read_data   RAM port (1-cycle read latency)

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_en,
    input  logic        cpu_write_en,
    input  logic [11:0] cpu_addr,
    input  logic [3:0]  cpu_write_data,
    output logic [3:0]  cpu_read_data,
    output logic        cpu_stall,
    input  logic        disp_req,
    input  logic [11:0] disp_addr,
    input  logic [3:0]  disp_len,
    output logic        disp_busy,
    output logic [3:0]  disp_data,
    output logic        disp_data_valid,
    output logic        disp_done,
    output logic [11:0] ram_addr,
    output logic        ram_write_en,
    output logic [3:0]  ram_write_data,
    input  logic [3:0]  ram_read_data
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [11:0] burst_addr_q, burst_addr_d;
    logic [3:0]  remaining_q, remaining_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        disp_valid_q, disp_valid_d;
    logic        disp_done_q, disp_done_d;

    logic        stall;
    logic        disp_grant;
    logic        cpu_grant;

    // Stall is decoded from registered state only, so it never depends on
    // cpu_mem_en and adds no combinational loop through the sequencer.
    always_comb begin
        stall      = (state_q == BURST) && (wait_cnt_q == LIMIT);
        cpu_grant  = cpu_mem_en && !stall;
        disp_grant = stall || (!cpu_mem_en && (state_q == BURST));
    end

    // RAM port mux. With no owner the address still follows the CPU.
    always_comb begin
        ram_addr       = cpu_addr;
        ram_write_en   = 1'b0;
        ram_write_data = cpu_write_data;
        if (disp_grant) begin
            ram_addr = burst_addr_q;
        end else if (cpu_grant) begin
            ram_write_en = cpu_write_en;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_addr_d = burst_addr_q;
        remaining_d  = remaining_q;
        wait_cnt_d   = wait_cnt_q;
        disp_valid_d = disp_grant;
        disp_done_d  = disp_grant && (remaining_q == 4'd0);

        case (state_q)
            IDLE: begin
                if (disp_req) begin
                    burst_addr_d = disp_addr;
                    remaining_d  = disp_len;
                    wait_cnt_d   = 4'd0;
                    state_d      = BURST;
                end
            end
            BURST: begin
                if (disp_grant) begin
                    // Bursts stay within their 256-nibble page.
                    burst_addr_d = {burst_addr_q[11:8], burst_addr_q[7:0] + 8'd1};
                    wait_cnt_d   = 4'd0;
                    if (remaining_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        remaining_d = remaining_q - 4'd1;
                    end
                end else if (cpu_grant && (wait_cnt_q != LIMIT)) begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            burst_addr_q <= 12'd0;
            remaining_q  <= 4'd0;
            wait_cnt_q   <= 4'd0;
            disp_valid_q <= 1'b0;
            disp_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_addr_q <= burst_addr_d;
            remaining_q  <= remaining_d;
            wait_cnt_q   <= wait_cnt_d;
            disp_valid_q <= disp_valid_d;
            disp_done_q  <= disp_done_d;
        end
    end

    assign cpu_stall       = stall;
    assign cpu_read_data   = ram_read_data;
    assign disp_data       = ram_read_data;
    assign disp_data_valid = disp_valid_q;
    assign disp_done       = disp_done_q;
    assign disp_busy       = (state_q == BURST);

endmodule
